// File: rtl/rom_rr_arbiter_if.sv
// -----------------------------------------------------------------------------
// rom_rr_arbiter_if
//
// Bundles the requester-side handshake and the ROM-side read port of the
// round-robin ROM arbiter.
//
// Signals (direction as seen by the arbiter, i.e. the 'slave' modport):
//   req_valid    in   [NUM_REQ]             requester i has a read pending
//   req_addr     in   [NUM_REQ*ADDR_WIDTH]  requester i address slice
//   req_ready    out  [NUM_REQ]             requester i accepted this cycle
//   resp_valid   out  [NUM_REQ]             response slot i holds data
//   resp_data    out  [NUM_REQ*DATA_WIDTH]  response slot i word slice
//   resp_ready   in   [NUM_REQ]             requester i consumes its response
//   rom_rd_en    out                        ROM read enable
//   rom_addr     out  [ADDR_WIDTH]          ROM address
//   rom_data_out in   [DATA_WIDTH]          ROM registered read data
//
// 'master' is the mirror view used by whatever surrounds the arbiter
// (clients plus the ROM instance, or a testbench).
// -----------------------------------------------------------------------------
interface rom_rr_arbiter_if #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 9
);

    // Requester side
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            resp_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] resp_data;
    logic [NUM_REQ-1:0]            resp_ready;

    // ROM side
    logic                          rom_rd_en;
    logic [ADDR_WIDTH-1:0]         rom_addr;
    logic [DATA_WIDTH-1:0]         rom_data_out;

    modport slave (
        input  req_valid,
        input  req_addr,
        input  resp_ready,
        input  rom_data_out,
        output req_ready,
        output resp_valid,
        output resp_data,
        output rom_rd_en,
        output rom_addr
    );

    modport master (
        output req_valid,
        output req_addr,
        output resp_ready,
        output rom_data_out,
        input  req_ready,
        input  resp_valid,
        input  resp_data,
        input  rom_rd_en,
        input  rom_addr
    );

endinterface

// File: rtl/rom_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rom_rr_arbiter
//
// Shares one single-port synchronous ROM (1-cycle registered read latency)
// among NUM_REQ requesters. At most one read is issued per cycle, chosen
// round-robin starting at a rotating pointer. The owner of the read in flight
// is tracked for one cycle, and the returning word lands in a per-requester
// response slot that is held until the requester consumes it.
//
// Ports:
//   clk   in   single clock, rising edge
//   rst   in   synchronous, active-high reset
//   bus   slave modport of rom_rr_arbiter_if (requester + ROM signals)
//
// Timing: accept in T, ROM data in T+1, resp_valid from T+2.
// There is no combinational path from rom_data_out to any output.
// -----------------------------------------------------------------------------
module rom_rr_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 9
) (
    input  logic            clk,
    input  logic            rst,
    rom_rr_arbiter_if.slave bus
);

    localparam int unsigned PTR_W = $clog2(NUM_REQ);

    typedef logic [PTR_W-1:0] idx_t;

    localparam idx_t LAST_IDX = idx_t'(NUM_REQ - 1);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    idx_t                          ptr_q,        ptr_d;
    logic                          inf_valid_q,  inf_valid_d;
    idx_t                          inf_id_q,     inf_id_d;
    logic [NUM_REQ-1:0]            resp_valid_q, resp_valid_d;
    logic [NUM_REQ*DATA_WIDTH-1:0] resp_data_q,  resp_data_d;

    // -------------------------------------------------------------------------
    // Combinational arbitration signals
    // -------------------------------------------------------------------------
    logic [NUM_REQ-1:0]            busy;
    logic [NUM_REQ-1:0]            elig;
    logic                          gnt_found;
    idx_t                          gnt_idx;
    logic [NUM_REQ-1:0]            gnt_onehot;
    logic [ADDR_WIDTH-1:0]         rom_addr_mux;

    // A requester is busy while its read is in flight or while its response
    // slot is occupied and not being drained this cycle. Draining in the same
    // cycle frees the slot early, which is what gives the 1-read-per-2-cycles
    // per-requester rate.
    always_comb begin
        busy = '0;
        elig = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            busy[i] = (inf_valid_q && (inf_id_q == idx_t'(i))) ||
                      (resp_valid_q[i] && !bus.resp_ready[i]);
            elig[i] = bus.req_valid[i] && !busy[i] && !rst;
        end
    end

    // Round-robin search: first eligible index at or after ptr_q, wrapping.
    // The wrap is a conditional subtract rather than a modulo so that
    // non-power-of-two NUM_REQ stays cheap.
    always_comb begin
        int unsigned cand;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = 32'(ptr_q) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!gnt_found && elig[cand[PTR_W-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand[PTR_W-1:0];
            end
        end
    end

    // One-hot grant and ROM address mux (AND-OR so no grant gives zero).
    always_comb begin
        gnt_onehot   = '0;
        rom_addr_mux = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            gnt_onehot[i] = gnt_found && (gnt_idx == idx_t'(i));
            if (gnt_onehot[i]) begin
                rom_addr_mux = rom_addr_mux |
                               bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        ptr_d       = ptr_q;
        inf_valid_d = gnt_found;
        inf_id_d    = inf_id_q;
        if (gnt_found) begin
            inf_id_d = gnt_idx;
            ptr_d    = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + idx_t'(1);
        end
    end

    // Release and capture never target the same slot in the same cycle:
    // capture needs a grant one cycle earlier, which the busy term blocks
    // while the slot is held. Released data words are left untouched.
    always_comb begin
        resp_valid_d = resp_valid_q & ~bus.resp_ready;
        resp_data_d  = resp_data_q;
        if (inf_valid_q) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (inf_id_q == idx_t'(i)) begin
                    resp_valid_d[i]                            = 1'b1;
                    resp_data_d[i*DATA_WIDTH +: DATA_WIDTH]    = bus.rom_data_out;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    // Reset also drops a read that is in flight, so no slot is filled for it.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q        <= '0;
            inf_valid_q  <= 1'b0;
            inf_id_q     <= '0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
        end else begin
            ptr_q        <= ptr_d;
            inf_valid_q  <= inf_valid_d;
            inf_id_q     <= inf_id_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus.req_ready  = gnt_onehot;
    assign bus.rom_rd_en  = gnt_found;
    assign bus.rom_addr   = rom_addr_mux;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;

endmodule

// File: doc/rom_rr_arbiter.md
# rom_rr_arbiter

Round-robin arbiter that shares one single-port synchronous ROM (registered output, 1-cycle read latency, `rd_en`/`addr`/`data_out` interface) among `NUM_REQ` independent requesters. It accepts at most one read per cycle, tracks the in-flight read's owner, and returns each word through a per-requester response register with valid/ready backpressure. It sits between the ROM instance and the client blocks that fetch table constants.

## Interface
- `NUM_REQ`, 4: number of requesters, ≥2.
- `ADDR_WIDTH`, 4: ROM address width.
- `DATA_WIDTH`, 9: ROM word width.
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in NUM_REQ: bit i means requester i has a read pending.
- `req_addr` in NUM_REQ*ADDR_WIDTH: requester i address at `[i*ADDR_WIDTH +: ADDR_WIDTH]`.
- `req_ready` out NUM_REQ: bit i means requester i's read is accepted this cycle; one-hot or zero.
- `resp_valid` out NUM_REQ: bit i means requester i's response slot holds data.
- `resp_data` out NUM_REQ*DATA_WIDTH: requester i word at `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `resp_ready` in NUM_REQ: bit i means requester i consumes its response this cycle.
- `rom_rd_en` out 1: ROM read enable.
- `rom_addr` out ADDR_WIDTH: ROM address.
- `rom_data_out` in DATA_WIDTH: ROM registered read data, valid the cycle after `rom_rd_en`.

## Operation
- **Eligibility.**
  - `busy_i` = (in-flight read owned by i) OR (`resp_valid[i]` AND NOT `resp_ready[i]`).
  - `elig_i` = `req_valid[i]` AND NOT `busy_i` AND NOT `rst`.
- **Grant.**
  - Combinational selection of the first eligible index at or after `ptr`, searching upward with wrap-around modulo NUM_REQ.
  - `req_ready[g]` = 1 for the granted index only.
  - `req_ready` may depend combinationally on `req_valid`; requesters must not make `req_valid` depend on `req_ready`.
- **Pointer.**
  - `ptr` resets to 0.
  - On a grant to g, `ptr` <= (g+1) mod NUM_REQ.
  - With no grant, `ptr` holds.
- **ROM drive.**
  - `rom_rd_en` = 1 iff a grant occurs.
  - `rom_addr` = `req_addr` slice of g when granted, else 0.
- **In-flight stage.**
  - On a grant, register `inf_valid`=1 and `inf_id`=g.
  - Otherwise `inf_valid`=0.
- **Capture.**
  - When `inf_valid`, at the end of that cycle set `resp_data[inf_id]` <= `rom_data_out` and `resp_valid[inf_id]` <= 1.
  - The slot is guaranteed free by the eligibility rule.
- **Release.** `resp_valid[i]` AND `resp_ready[i]` clears `resp_valid[i]` at the edge. `resp_data[i]` retains its value.
- **Simultaneous release and capture.** Capture into the same slot cannot collide: it requires a prior grant, which is blocked while the slot is held.
- **Data integrity.** Out-of-range or X ROM data is passed through unmodified; the arbiter does no checking.
- **Reset.**
  - All of the following are 0: `ptr`, `inf_valid`, `inf_id`, every `resp_valid` bit, every `resp_data` word.
  - `rom_rd_en`=0, `rom_addr`=0, `req_ready`=0 while `rst` is high.
- **Reset mid-operation.** An in-flight read is discarded; no `resp_valid` is raised for it after reset deasserts.

## Timing
- Accept in cycle T (`req_valid[i]` & `req_ready[i]`): ROM samples address at the end of T; `rom_data_out` is valid in T+1; `resp_valid[i]` is high from T+2.
- Accept-to-response latency: 2 cycles.
- Aggregate throughput: 1 read/cycle across different requesters.
- Per-requester rate: a requester whose response is consumed in T+2 is eligible again in T+2, giving 1 read per 2 cycles.
- `resp_valid[i]` and `resp_data[i]` stay stable while `resp_ready[i]`=0.
- No combinational path from `rom_data_out` to any output.

## Test plan
Bench ROM model: registered output, word k = k.
- **Reset.** Hold `rst` for 3 cycles with all `req_valid`=1 -> `req_ready`=0, `rom_rd_en`=0, `resp_valid`=0, `resp_data`=0 throughout.
- **Single read.** Requester 0 reads addr 5 at cycle T -> `rom_rd_en`=1 and `rom_addr`=5 in T; `resp_valid[0]`=1 with `resp_data[0]`=0x005 in T+2; cleared the cycle after `resp_ready[0]`.
- **Four-way contention.** All four requesters valid from cycle T with addrs 1,2,3,4, `ptr`=0, `resp_ready`=all 1 -> grants 0,1,2,3 in T..T+3; responses 0x001..0x004 in T+2..T+5.
- **Fairness.** Requesters 0 and 2 continuously valid, `resp_ready`=1 -> grants alternate 0,2,0,2; no requester waits more than NUM_REQ-1 grants.
- **Backpressure.** `resp_ready[1]`=0 with `resp_valid[1]` high and `resp_data[1]`=0x003 -> both stay stable; requester 1 is never granted while the others keep being served. Raising `resp_ready[1]` -> requester 1 is granted that same cycle.
- **Reset mid-operation.** Assert `rst` in T+1 after a grant in T -> no `resp_valid` after release; the next grant follows from `ptr`=0.
